// File: rtl/fp_pkg.sv
// Shared types and constants for the FP divide/sqrt unit.
// Latency: n/a (package).
// Backpressure: n/a (package).
package fp_pkg;

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_ITER, S_ROUND} state_t;

  typedef enum logic [2:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_QNAN, CLS_SNAN} cls_t;

  // fflags bit positions {NV,DZ,OF,UF,NX}
  localparam int FF_NV = 4;
  localparam int FF_DZ = 3;
  localparam int FF_OF = 2;
  localparam int FF_UF = 1;
  localparam int FF_NX = 0;

  localparam logic [31:0] CNAN32 = 32'h7fc0_0000;
  localparam logic [63:0] CNAN64 = 64'h7ff8_0000_0000_0000;

  function automatic int fw_of(input int w);
    return (w == 64) ? 52 : 23;
  endfunction

  function automatic int ew_of(input int w);
    return (w == 64) ? 11 : 8;
  endfunction

  function automatic int bias_of(input int w);
    return (1 << (ew_of(w) - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_divsqrt_if.sv
// Request/response bundle between the FP pipe and the divide/sqrt unit.
// Latency: n/a (wiring only).
// Backpressure: start is honoured only while ready=1; no queueing.
interface fp_divsqrt_if #(
  parameter int W            = 32,
  parameter int LG_ROB_WIDTH = 1,
  parameter int LG_PRF_WIDTH = 1
);
  logic                    start;
  logic                    is_sqrt;
  logic [W-1:0]            a;
  logic [W-1:0]            b;
  logic [LG_ROB_WIDTH-1:0] rob_ptr_in;
  logic [LG_PRF_WIDTH-1:0] dst_ptr_in;
  logic                    flush;
  logic                    ready;
  logic                    active;
  logic                    valid;
  logic [W-1:0]            y;
  logic [4:0]              fflags;
  logic [LG_ROB_WIDTH-1:0] rob_ptr_out;
  logic [LG_PRF_WIDTH-1:0] dst_ptr_out;

  modport master (
    output start, is_sqrt, a, b, rob_ptr_in, dst_ptr_in, flush,
    input  ready, active, valid, y, fflags, rob_ptr_out, dst_ptr_out
  );

  modport slave (
    input  start, is_sqrt, a, b, rob_ptr_in, dst_ptr_in, flush,
    output ready, active, valid, y, fflags, rob_ptr_out, dst_ptr_out
  );
endinterface

// File: rtl/fp_classify.sv
// Splits an IEEE operand into class, sign, biased exponent and hidden-bit mantissa (subnormals flushed to zero).
// Latency: combinational.
// Backpressure: none.
module fp_classify
  import fp_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0]         x,
  output cls_t                 cls,
  output logic                 sign,
  output logic [ew_of(W)-1:0]  expo,
  output logic [fw_of(W):0]    mant
);
  localparam int FW = fw_of(W);
  localparam int EW = ew_of(W);

  // decode fields; zero exponent (zero or subnormal) collapses to signed zero
  always_comb begin
    sign = x[W-1];
    expo = x[W-2:FW];
    mant = {1'b1, x[FW-1:0]};
    cls  = CLS_NORM;
    if (x[W-2:FW] == '0) begin
      cls  = CLS_ZERO;
      expo = '0;
      mant = '0;
    end else if (x[W-2:FW] == {EW{1'b1}}) begin
      if (x[FW-1:0] == '0)  cls = CLS_INF;
      else if (x[FW-1])     cls = CLS_QNAN;
      else                  cls = CLS_SNAN;
    end
  end
endmodule

// File: rtl/fp_divsqrt.sv
// IEEE binary32/64 divide and square root, RNE rounding, RISC-V fflags, shared radix-2 recurrence.
// Latency: FW+4 cycles accept-to-valid for normal operands, 2 cycles for special operands.
// Backpressure: one op at a time; start ignored while busy, flush aborts and suppresses valid.
module fp_divsqrt
  import fp_pkg::*;
#(
  parameter int W            = 32,
  parameter int LG_ROB_WIDTH = 1,
  parameter int LG_PRF_WIDTH = 1
) (
  input  logic        clk,
  input  logic        reset,
  fp_divsqrt_if.slave io
);
  localparam int FW   = fw_of(W);
  localparam int EW   = ew_of(W);
  localparam int Q    = FW + 2;        // integer bit + FW fraction bits + guard
  localparam int RW   = Q + 2;         // remainder width, covers both div and sqrt bounds
  localparam int XW   = EW + 2;        // signed exponent, cannot wrap
  localparam int CW   = $clog2(Q);
  localparam logic signed [XW-1:0] BIAS_X = XW'(bias_of(W));
  localparam logic signed [XW-1:0] EMAX_X = XW'((1 << EW) - 1);
  localparam logic [63:0]  CNAN_WIDE = (W == 64) ? CNAN64 : {32'd0, CNAN32};
  localparam logic [W-1:0] CNAN      = CNAN_WIDE[W-1:0];
  localparam logic [W-1:0] INF       = {1'b0, {EW{1'b1}}, {FW{1'b0}}};

  state_t                  state_q, state_d;
  logic [W-1:0]            a_q, a_d, b_q, b_d;
  logic                    sqrt_q, sqrt_d;
  logic [LG_ROB_WIDTH-1:0] rob_q, rob_d, rob_out_q, rob_out_d;
  logic [LG_PRF_WIDTH-1:0] dst_q, dst_d, dst_out_q, dst_out_d;
  logic [RW-1:0]           rem_q, rem_d;
  logic [Q-1:0]            quo_q, quo_d;
  logic [2*Q-1:0]          opnd_q, opnd_d;   // divisor (div) or radicand bit pairs (sqrt)
  logic [CW-1:0]           cnt_q, cnt_d;
  logic signed [XW-1:0]    exp_q, exp_d;
  logic                    sign_q, sign_d, spec_q, spec_d, valid_q, valid_d;
  logic [W-1:0]            spec_y_q, spec_y_d, y_q, y_d;
  logic [4:0]              spec_f_q, spec_f_d, fflags_q, fflags_d;

  cls_t          cls_a, cls_b;
  logic          sa, sb;
  logic [EW-1:0] ea, eb;
  logic [FW:0]   ma, mb;

  fp_classify #(.W(W)) u_cls_a (.x(a_q), .cls(cls_a), .sign(sa), .expo(ea), .mant(ma));
  fp_classify #(.W(W)) u_cls_b (.x(b_q), .cls(cls_b), .sign(sb), .expo(eb), .mant(mb));

  logic       spec_hit, a_nan, b_nan, any_snan, dsign;
  logic [W-1:0] spec_res;
  logic [4:0] spec_flg;

  // special-operand result, decided from the captured operands during PREP
  always_comb begin
    spec_hit = 1'b1;
    spec_res = CNAN;
    spec_flg = '0;
    a_nan    = (cls_a == CLS_QNAN) || (cls_a == CLS_SNAN);
    b_nan    = (cls_b == CLS_QNAN) || (cls_b == CLS_SNAN);
    any_snan = (cls_a == CLS_SNAN) || (cls_b == CLS_SNAN);
    dsign    = sa ^ sb;
    if (sqrt_q) begin
      if (a_nan)                   spec_flg[FF_NV] = (cls_a == CLS_SNAN);
      else if (cls_a == CLS_ZERO)  spec_res = {sa, {(W-1){1'b0}}};
      else if (sa)                 spec_flg[FF_NV] = 1'b1;
      else if (cls_a == CLS_INF)   spec_res = INF;
      else                         spec_hit = 1'b0;
    end else begin
      if (a_nan || b_nan) begin
        spec_flg[FF_NV] = any_snan;
      end else if ((cls_a == CLS_ZERO && cls_b == CLS_ZERO) ||
                   (cls_a == CLS_INF  && cls_b == CLS_INF)) begin
        spec_flg[FF_NV] = 1'b1;
      end else if (cls_a == CLS_INF) begin
        spec_res = {dsign, INF[W-2:0]};
      end else if (cls_b == CLS_ZERO) begin
        spec_res        = {dsign, INF[W-2:0]};
        spec_flg[FF_DZ] = 1'b1;
      end else if (cls_b == CLS_INF || cls_a == CLS_ZERO) begin
        spec_res = {dsign, {(W-1){1'b0}}};
      end else begin
        spec_hit = 1'b0;
      end
    end
  end

  logic signed [XW-1:0] ea_x, eb_x, eunb, ediv, esq;
  logic                 m_lt;
  logic [FW+1:0]        rad;

  // exponent and mantissa alignment so the recurrence result lands in [1,2)
  always_comb begin
    ea_x = $signed({2'b00, ea});
    eb_x = $signed({2'b00, eb});
    eunb = ea_x - BIAS_X;
    m_lt = ma < mb;
    ediv = ea_x - eb_x + BIAS_X - $signed({{(XW-1){1'b0}}, m_lt});
    esq  = (eunb >>> 1) + BIAS_X;
    rad  = eunb[0] ? {ma, 1'b0} : {1'b0, ma};
  end

  logic             d_ge, s_ge;
  logic [RW-1:0]    d_rem, s_nrem;
  logic [RW+1:0]    s_rem, s_trial;

  // one restoring step: divide subtracts the divisor, sqrt subtracts 4*root+1
  always_comb begin
    d_ge    = rem_q >= opnd_q[RW-1:0];
    d_rem   = (d_ge ? (rem_q - opnd_q[RW-1:0]) : rem_q) << 1;
    s_rem   = {rem_q, opnd_q[2*Q-1 -: 2]};
    s_trial = {2'b00, quo_q, 2'b01};
    s_ge    = s_rem >= s_trial;
    s_nrem  = s_ge ? RW'(s_rem - s_trial) : RW'(s_rem);
  end

  logic                 g, st, up, carry;
  logic [FW:0]          mant;
  logic [FW+1:0]        msum;
  logic [FW-1:0]        frac;
  logic signed [XW-1:0] er;
  logic [W-1:0]         rnd_y;
  logic [4:0]           rnd_f;

  // round to nearest even, then overflow / flush-to-zero range checks
  always_comb begin
    g     = quo_q[0];
    st    = |rem_q;
    mant  = quo_q[Q-1:1];
    up    = g & (st | mant[0]);
    msum  = {1'b0, mant} + {{(FW+1){1'b0}}, up};
    carry = msum[FW+1];
    frac  = carry ? msum[FW:1] : msum[FW-1:0];
    er    = exp_q + $signed({{(XW-1){1'b0}}, carry});
    rnd_f = '0;
    rnd_f[FF_NX] = g | st;
    rnd_y = {sign_q, er[EW-1:0], frac};
    if (er >= EMAX_X) begin
      rnd_y = {sign_q, INF[W-2:0]};
      rnd_f[FF_OF] = 1'b1;
      rnd_f[FF_NX] = 1'b1;
    end else if (er <= '0) begin
      rnd_y = {sign_q, {(W-1){1'b0}}};
      rnd_f[FF_UF] = 1'b1;
      rnd_f[FF_NX] = 1'b1;
    end
  end

  // control FSM: next state and all register next-values
  always_comb begin
    state_d   = state_q;   a_d      = a_q;      b_d      = b_q;
    sqrt_d    = sqrt_q;    rob_d    = rob_q;    dst_d    = dst_q;
    rem_d     = rem_q;     quo_d    = quo_q;    opnd_d   = opnd_q;
    cnt_d     = cnt_q;     exp_d    = exp_q;    sign_d   = sign_q;
    spec_d    = spec_q;    spec_y_d = spec_y_q; spec_f_d = spec_f_q;
    y_d       = y_q;       fflags_d = fflags_q; valid_d  = 1'b0;
    rob_out_d = rob_out_q; dst_out_d = dst_out_q;
    case (state_q)
      S_IDLE: if (io.start) begin
        a_d = io.a;  b_d = io.b;  sqrt_d = io.is_sqrt;
        rob_d = io.rob_ptr_in;  dst_d = io.dst_ptr_in;
        state_d = S_PREP;
      end
      S_PREP: begin
        spec_d   = spec_hit;
        spec_y_d = spec_res;
        spec_f_d = spec_flg;
        sign_d   = sqrt_q ? 1'b0 : dsign;
        exp_d    = sqrt_q ? esq : ediv;
        quo_d    = '0;
        cnt_d    = CW'(Q - 1);
        if (sqrt_q) begin
          rem_d  = '0;
          opnd_d = {rad, {(FW+2){1'b0}}};
        end else begin
          rem_d  = m_lt ? {2'b00, ma, 1'b0} : {3'b000, ma};
          opnd_d = {{(FW+3){1'b0}}, mb};
        end
        state_d = spec_hit ? S_ROUND : S_ITER;
      end
      S_ITER: begin
        rem_d  = sqrt_q ? s_nrem : d_rem;
        quo_d  = {quo_q[Q-2:0], sqrt_q ? s_ge : d_ge};
        opnd_d = sqrt_q ? (opnd_q << 2) : opnd_q;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = S_ROUND;
      end
      S_ROUND: begin
        valid_d   = 1'b1;
        y_d       = spec_q ? spec_y_q : rnd_y;
        fflags_d  = spec_q ? spec_f_q : rnd_f;
        rob_out_d = rob_q;
        dst_out_d = dst_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (io.flush) begin
      state_d   = S_IDLE;
      valid_d   = 1'b0;
      y_d       = y_q;
      fflags_d  = fflags_q;
      rob_out_d = rob_out_q;
      dst_out_d = dst_out_q;
    end
  end

  // state and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;  a_q <= '0;  b_q <= '0;  sqrt_q <= 1'b0;
      rob_q <= '0;  dst_q <= '0;  rem_q <= '0;  quo_q <= '0;  opnd_q <= '0;
      cnt_q <= '0;  exp_q <= '0;  sign_q <= 1'b0;  spec_q <= 1'b0;
      spec_y_q <= '0;  spec_f_q <= '0;  y_q <= '0;  fflags_q <= '0;
      valid_q <= 1'b0;  rob_out_q <= '0;  dst_out_q <= '0;
    end else begin
      state_q <= state_d;  a_q <= a_d;  b_q <= b_d;  sqrt_q <= sqrt_d;
      rob_q <= rob_d;  dst_q <= dst_d;  rem_q <= rem_d;  quo_q <= quo_d;  opnd_q <= opnd_d;
      cnt_q <= cnt_d;  exp_q <= exp_d;  sign_q <= sign_d;  spec_q <= spec_d;
      spec_y_q <= spec_y_d;  spec_f_q <= spec_f_d;  y_q <= y_d;  fflags_q <= fflags_d;
      valid_q <= valid_d;  rob_out_q <= rob_out_d;  dst_out_q <= dst_out_d;
    end
  end

  assign io.ready       = (state_q == S_IDLE);
  assign io.active      = (state_q != S_IDLE);
  assign io.valid       = valid_q;
  assign io.y           = y_q;
  assign io.fflags      = fflags_q;
  assign io.rob_ptr_out = rob_out_q;
  assign io.dst_ptr_out = dst_out_q;
endmodule

// File: tb/tb_fp_divsqrt.sv
// Directed-vector bench for fp_divsqrt at W=32 and W=64.
// Latency: checks exact accept-to-valid cycle counts.
// Backpressure: exercises flush, start-with-flush and back-to-back start.
module tb_fp_divsqrt;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fp_divsqrt_if #(.W(32)) if32 ();
  fp_divsqrt_if #(.W(64)) if64 ();

  fp_divsqrt #(.W(32)) u_dut32 (.clk(clk), .reset(reset), .io(if32));
  fp_divsqrt #(.W(64)) u_dut64 (.clk(clk), .reset(reset), .io(if64));

  int errs   = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // drive one request at #1 after an edge; returns #1 after the accept edge
  task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic sq,
                         input logic rob, input logic dst);
    if32.a = a;  if32.b = b;  if32.is_sqrt = sq;
    if32.rob_ptr_in = rob;  if32.dst_ptr_in = dst;
    if32.start = 1'b1;
    @(posedge clk); #1;
    if32.start = 1'b0;
  endtask

  task automatic wait32(output int lat, output bit seen);
    lat = 0; seen = 1'b0;
    while (!seen && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (if32.valid) seen = 1'b1;
    end
  endtask

  task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic sq, input logic [31:0] ey, input logic [4:0] ef, input int elat);
    int lat; bit seen;
    issue32(a, b, sq, 1'b0, 1'b0);
    wait32(lat, seen);
    check({tag, "_valid"}, 64'(seen), 64'd1);
    check({tag, "_y"}, 64'(if32.y), 64'(ey));
    check({tag, "_flags"}, 64'(if32.fflags), 64'(ef));
    check({tag, "_lat"}, 64'(lat), 64'(elat));
  endtask

  initial begin
    int lat; bit seen; int nv;
    if32.start = 0; if32.is_sqrt = 0; if32.a = '0; if32.b = '0;
    if32.rob_ptr_in = 0; if32.dst_ptr_in = 0; if32.flush = 0;
    if64.start = 0; if64.is_sqrt = 0; if64.a = '0; if64.b = '0;
    if64.rob_ptr_in = 0; if64.dst_ptr_in = 0; if64.flush = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",  64'(if32.ready),  64'd1);
    check("rst_active", 64'(if32.active), 64'd0);
    check("rst_valid",  64'(if32.valid),  64'd0);
    check("rst_y",      64'(if32.y),      64'd0);
    check("rst_flags",  64'(if32.fflags), 64'd0);
    check("rst_rob",    64'(if32.rob_ptr_out), 64'd0);
    check("rst_y64",    if64.y,           64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run32("div6_2",   32'h40c00000, 32'h40000000, 0, 32'h40400000, 5'h00, 27);
    run32("div1_3",   32'h3f800000, 32'h40400000, 0, 32'h3eaaaaab, 5'h01, 27);
    run32("sqrt2",    32'h40000000, 32'h0,        1, 32'h3fb504f3, 5'h01, 27);
    run32("sqrt4",    32'h40800000, 32'h0,        1, 32'h40000000, 5'h00, 27);
    run32("sqrtneg1", 32'hbf800000, 32'h0,        1, 32'h7fc00000, 5'h10, 2);
    run32("sqrtneg0", 32'h80000000, 32'h0,        1, 32'h80000000, 5'h00, 2);
    run32("div1_0",   32'h3f800000, 32'h00000000, 0, 32'h7f800000, 5'h08, 2);
    run32("div0_0",   32'h00000000, 32'h00000000, 0, 32'h7fc00000, 5'h10, 2);
    run32("divsnan",  32'h7f800001, 32'h3f800000, 0, 32'h7fc00000, 5'h10, 2);
    run32("divovf",   32'h7f7fffff, 32'h3f000000, 0, 32'h7f800000, 5'h05, 27);
    run32("divunf",   32'h00800000, 32'h40000000, 0, 32'h00000000, 5'h03, 27);
    run32("divneg",   32'hc0c00000, 32'h40000000, 0, 32'hc0400000, 5'h00, 27);
    run32("divftz",   32'h00000001, 32'h3f800000, 0, 32'h00000000, 5'h00, 2);
    run32("divxinf",  32'h40400000, 32'hff800000, 0, 32'h80000000, 5'h00, 2);
    run32("div6_2b",  32'h40c00000, 32'h40000000, 0, 32'h40400000, 5'h00, 27);

    // valid is a single-cycle strobe and the result holds afterwards
    @(posedge clk); #1;
    check("strobe_low", 64'(if32.valid), 64'd0);
    check("hold_y",     64'(if32.y),     64'h40400000);

    // flush 10 cycles after accept: no valid, outputs hold
    issue32(32'h3f800000, 32'h40400000, 1'b0, 1'b1, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    if32.flush = 1'b1;
    @(posedge clk); #1;
    if32.flush = 1'b0;
    check("flush_ready", 64'(if32.ready), 64'd1);
    nv = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (if32.valid) nv++;
    end
    check("flush_novalid", 64'(nv), 64'd0);
    check("flush_hold_y",  64'(if32.y), 64'h40400000);
    check("flush_hold_rob", 64'(if32.rob_ptr_out), 64'd0);

    // start together with flush in IDLE is dropped
    if32.a = 32'h40c00000; if32.b = 32'h40000000; if32.is_sqrt = 1'b0;
    if32.start = 1'b1; if32.flush = 1'b1;
    @(posedge clk); #1;
    if32.start = 1'b0; if32.flush = 1'b0;
    check("sflush_ready", 64'(if32.ready), 64'd1);
    nv = 0;
    repeat (35) begin
      @(posedge clk); #1;
      if (if32.valid) nv++;
    end
    check("sflush_novalid", 64'(nv), 64'd0);

    // recovery, then back-to-back start in the valid cycle with tags
    run32("post_flush", 32'h40c00000, 32'h40000000, 0, 32'h40400000, 5'h00, 27);
    issue32(32'h3f800000, 32'h40400000, 1'b0, 1'b1, 1'b1);
    wait32(lat, seen);
    check("b2b_valid", 64'(seen), 64'd1);
    check("b2b_lat",   64'(lat),  64'd27);
    check("b2b_y",     64'(if32.y), 64'h3eaaaaab);
    check("b2b_rob",   64'(if32.rob_ptr_out), 64'd1);
    check("b2b_dst",   64'(if32.dst_ptr_out), 64'd1);

    // W=64: 9/3 with tags echoed
    if64.a = 64'h4022000000000000; if64.b = 64'h4008000000000000;
    if64.is_sqrt = 1'b0; if64.rob_ptr_in = 1'b1; if64.dst_ptr_in = 1'b1;
    if64.start = 1'b1;
    @(posedge clk); #1;
    if64.start = 1'b0;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 150) begin
      @(posedge clk); #1;
      lat++;
      if (if64.valid) seen = 1'b1;
    end
    check("d64_valid", 64'(seen), 64'd1);
    check("d64_y",     if64.y, 64'h4008000000000000);
    check("d64_flags", 64'(if64.fflags), 64'd0);
    check("d64_lat",   64'(lat), 64'd56);
    check("d64_rob",   64'(if64.rob_ptr_out), 64'd1);
    check("d64_dst",   64'(if64.dst_ptr_out), 64'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
